// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vram_arbiter
// Purpose  : Single-port video RAM arbiter between the chroni text/font fetch
//            path and the CPU. Video always owns the slot it asks for and sees
//            a fixed 2-cycle read latency. The CPU uses a req/ack handshake
//            with a 1-entry posted write buffer. CPU reads use free slots only.
// Ports    : vga_clk, reset           - clock, async active-high reset
//            vid_req/vid_addr         - video read request
//            vid_data/vid_valid       - video read result (2 cycles later)
//            cpu_req/we/addr/wdata    - CPU request, held until cpu_ack
//            cpu_ack/cpu_rdata        - CPU completion pulse and read data
//            mem_addr/we/wdata        - registered RAM command
//            mem_rdata                - RAM read data (1 cycle after address)
// Revision : 1.0 - initial release
// ============================================================================
module vram_arbiter #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_valid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_WAIT = 3'd1,
        ST_RD_P1   = 3'd2,
        ST_RD_P2   = 3'd3,
        ST_ACK     = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_vid_p1;
    logic                r_wbuf_valid;
    logic [ADDR_W-1:0]   r_wbuf_addr;
    logic [DATA_W-1:0]   r_wbuf_data;

    logic                w_slot_free;
    logic                w_drain;
    logic                w_rd_issue;
    logic                w_wr_capture;

    // Video owns any cycle it requests; the buffered write drains next,
    // and a CPU read only issues once neither of those needs the slot.
    // Draining before any read keeps CPU accesses in program order.
    assign w_slot_free = !vid_req && !r_wbuf_valid;
    assign w_drain     = !vid_req &&  r_wbuf_valid;

    assign vid_data = mem_rdata;
    assign cpu_ack  = (r_state == ST_ACK);

    always_comb begin
        w_state_nxt  = r_state;
        w_rd_issue   = 1'b0;
        w_wr_capture = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cpu_req) begin
                    if (cpu_we) begin
                        // A full buffer simply holds the request in IDLE
                        // until the drain frees the entry.
                        if (!r_wbuf_valid) begin
                            w_wr_capture = 1'b1;
                            w_state_nxt  = ST_ACK;
                        end
                    end else if (w_slot_free) begin
                        w_rd_issue  = 1'b1;
                        w_state_nxt = ST_RD_P1;
                    end else begin
                        w_state_nxt = ST_RD_WAIT;
                    end
                end
            end
            ST_RD_WAIT: begin
                if (w_slot_free) begin
                    w_rd_issue  = 1'b1;
                    w_state_nxt = ST_RD_P1;
                end
            end
            ST_RD_P1: w_state_nxt = ST_RD_P2;
            ST_RD_P2: w_state_nxt = ST_ACK;
            ST_ACK:   w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_vid_p1     <= 1'b0;
            vid_valid    <= 1'b0;
            r_wbuf_valid <= 1'b0;
            r_wbuf_addr  <= '0;
            r_wbuf_data  <= '0;
            mem_addr     <= '0;
            mem_we       <= 1'b0;
            mem_wdata    <= '0;
            cpu_rdata    <= '0;
        end else begin
            // Two-stage tracker: address cycle, then RAM data cycle.
            r_vid_p1  <= vid_req;
            vid_valid <= r_vid_p1;

            // Idle slots leave mem_addr untouched.
            if (vid_req) begin
                mem_addr <= vid_addr;
            end else if (w_drain) begin
                mem_addr  <= r_wbuf_addr;
                mem_wdata <= r_wbuf_data;
            end else if (w_rd_issue) begin
                mem_addr <= cpu_addr;
            end
            mem_we <= w_drain;

            // Capture and drain are mutually exclusive: capture needs an
            // empty buffer, drain needs a full one.
            if (w_wr_capture) begin
                r_wbuf_valid <= 1'b1;
                r_wbuf_addr  <= cpu_addr;
                r_wbuf_data  <= cpu_wdata;
            end else if (w_drain) begin
                r_wbuf_valid <= 1'b0;
            end

            // RAM data for the address issued two cycles back lands here.
            if (r_state == ST_RD_P2) begin
                cpu_rdata <= mem_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vram_arbiter
// Purpose  : Self-checking bench for vram_arbiter: directed timing scenarios
//            followed by randomized CPU traffic against a shadow memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vram_arbiter;

    logic        vga_clk = 1'b0;
    logic        reset   = 1'b1;
    logic        vid_req = 1'b0;
    logic [10:0] vid_addr = '0;
    logic [7:0]  vid_data;
    logic        vid_valid;
    logic        cpu_req = 1'b0;
    logic        cpu_we  = 1'b0;
    logic [10:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic [10:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;

    vram_arbiter #(.ADDR_W(11), .DATA_W(8)) dut (
        .vga_clk   (vga_clk),
        .reset     (reset),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_data  (vid_data),
        .vid_valid (vid_valid),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 vga_clk = ~vga_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Initial RAM image; video only ever reads 0x400-0x7FE, which the CPU
    // never writes, so video expectations come straight from this function.
    function automatic logic [7:0] init_val(input logic [10:0] a);
        logic [7:0] v;
        if (a == 11'h400)      v = 8'h41;
        else if (a == 11'h7FF) v = 8'hC3;
        else                   v = a[7:0] * 8'd7 + {5'd0, a[10:8]};
        return v;
    endfunction

    // 2Kx8 synchronous RAM model plus a log of every write it receives.
    logic [7:0]  ram    [2048];
    logic [7:0]  shadow [2048];
    logic [18:0] wlog[$];

    always @(posedge vga_clk) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            wlog.push_back({mem_addr, mem_wdata});
        end
        mem_rdata <= ram[mem_addr];
    end

    // Video request history as seen at each clock edge.
    logic [1:0]  vh;
    logic [10:0] va0, va1;
    always @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            vh <= '0; va0 <= '0; va1 <= '0;
        end else begin
            vh  <= {vh[0], vid_req};
            va0 <= vid_addr;
            va1 <= va0;
        end
    end

    // Continuous video checks: request in N -> address in N+1 (no write),
    // valid data in N+2 and nowhere else.
    always @(negedge vga_clk) begin
        if (!reset) begin
            check("vid_valid", vid_valid, vh[1]);
            if (vh[1]) check("vid_data", vid_data, init_val(va1));
            if (vh[0]) begin
                check("vid_mem_addr", mem_addr, va0);
                check("vid_slot_we", mem_we, 0);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge vga_clk); #1; end
    endtask

    function automatic logic [10:0] rand_vaddr();
        return 11'h400 + 11'($urandom_range(0, 1022));
    endfunction

    task automatic vid_burst(input int n);
        for (int i = 0; i < n; i++) begin
            vid_req  = 1'b1;
            vid_addr = rand_vaddr();
            idle(1);
        end
        vid_req = 1'b0;
    endtask

    // One CPU transaction; lat = cycles from request cycle to ack cycle.
    task automatic cpu_op(input logic we, input logic [10:0] a, input logic [7:0] d,
                          output logic [7:0] rd, output int lat);
        logic [7:0] exp;
        bit got;
        exp = shadow[a];
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        lat = 0; got = 0; rd = '0;
        while (!got && lat < 300) begin
            @(negedge vga_clk);
            if (cpu_ack) begin
                got = 1;
                rd  = cpu_rdata;
            end else begin
                idle(1);
                lat++;
            end
        end
        idle(1);
        cpu_req = 1'b0; cpu_we = 1'b0;
        check("cpu_ack_seen", got, 1);
        if (got) begin
            if (we) shadow[a] = d;
            else    check("cpu_rdata_model", rd, exp);
        end
    endtask

    task automatic random_op();
        logic [7:0] rd;
        int lat;
        cpu_op(1'($urandom % 2), 11'($urandom % 256), 8'($urandom), rd, lat);
        idle($urandom % 3);
    endtask

    bit stop_vid;

    initial begin
        logic [7:0] rd;
        int lat;
        for (int i = 0; i < 2048; i++) begin
            ram[i]    = init_val(11'(i));
            shadow[i] = init_val(11'(i));
        end

        // Reset state
        repeat (3) @(posedge vga_clk);
        @(negedge vga_clk);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_cpu_ack", cpu_ack, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_vid_valid", vid_valid, 0);
        @(posedge vga_clk); #1;
        reset = 1'b0;
        idle(2);

        // Video latency
        vid_req = 1'b1; vid_addr = 11'h400;
        idle(1);
        vid_req = 1'b0; vid_addr = 11'h7FF;
        @(negedge vga_clk);
        check("vlat_addr_n1", mem_addr, 11'h400);
        check("vlat_valid_n1", vid_valid, 0);
        idle(1);
        @(negedge vga_clk);
        check("vlat_valid_n2", vid_valid, 1);
        check("vlat_data_n2", vid_data, 8'h41);
        idle(1);
        @(negedge vga_clk);
        check("vlat_valid_n3", vid_valid, 0);
        idle(2);

        // Write then read
        wlog.delete();
        cpu_op(1'b1, 11'h123, 8'h5A, rd, lat);
        check("wr_lat", lat, 1);
        cpu_op(1'b0, 11'h123, 8'h00, rd, lat);
        check("rd_lat", lat, 3);
        check("rd_data", rd, 8'h5A);
        check("wr_log_n", wlog.size(), 1);
        if (wlog.size() >= 1) check("wr_log0", wlog[0], {11'h123, 8'h5A});
        idle(2);

        // Write-buffer stall under a 5-cycle video burst
        wlog.delete();
        fork
            vid_burst(5);
            begin
                cpu_op(1'b1, 11'h010, 8'hA1, rd, lat);
                check("stall_wr1_lat", lat, 1);
                cpu_op(1'b1, 11'h011, 8'hB2, rd, lat);
                check("stall_wr2_lat", lat, 5);
            end
        join
        idle(4);
        check("stall_log_n", wlog.size(), 2);
        if (wlog.size() >= 2) begin
            check("stall_log0", wlog[0], {11'h010, 8'hA1});
            check("stall_log1", wlog[1], {11'h011, 8'hB2});
        end

        // Read blocked by an 8-cycle video burst
        fork
            vid_burst(8);
            cpu_op(1'b0, 11'h7FF, 8'h00, rd, lat);
        join
        check("blk_rd_lat", lat, 11);
        check("blk_rd_data", rd, 8'hC3);
        idle(3);

        // Reset while the read is in RD_P1
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h055;
        idle(1);
        reset = 1'b1; cpu_req = 1'b0;
        #1;
        check("mrst_mem_addr", mem_addr, 0);
        check("mrst_mem_we", mem_we, 0);
        check("mrst_cpu_ack", cpu_ack, 0);
        check("mrst_vid_valid", vid_valid, 0);
        idle(2);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge vga_clk);
            check("mrst_no_ack", cpu_ack, 0);
            idle(1);
        end
        cpu_op(1'b0, 11'h000, 8'h00, rd, lat);
        check("mrst_rd_lat", lat, 3);
        check("mrst_rd_data", rd, init_val(11'h000));
        cpu_op(1'b0, 11'h055, 8'h00, rd, lat);
        check("mrst_rd2_data", rd, init_val(11'h055));

        // Saturation: video on every other cycle with random CPU traffic
        stop_vid = 0;
        fork
            begin
                while (!stop_vid) begin
                    vid_req  = ~vid_req;
                    vid_addr = rand_vaddr();
                    idle(1);
                end
                vid_req = 1'b0;
            end
            begin
                repeat (150) random_op();
                stop_vid = 1;
            end
        join

        // Random video density with random CPU traffic
        stop_vid = 0;
        fork
            begin
                while (!stop_vid) begin
                    vid_req  = ($urandom % 10) < 3;
                    vid_addr = rand_vaddr();
                    idle(1);
                end
                vid_req = 1'b0;
            end
            begin
                repeat (150) random_op();
                stop_vid = 1;
            end
        join
        idle(6);

        // Every CPU write landed in RAM, last one wins
        for (int a = 0; a < 256; a++) check("ram_final", ram[a], shadow[a]);
        check("ram_final_123", ram[11'h123], shadow[11'h123]);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port video RAM arbiter between the chroni text/font fetch path and the CPU. The video path always wins a cycle and sees a fixed 2-cycle read latency, matching chroni's read-text → read-font spacing. The CPU side uses a req/ack handshake with a 1-entry posted write buffer; CPU reads are issued only in free cycles. The block sits between chroni's `addr_out`/`data_in` and the 2K×8 synchronous video RAM.

## Interface
- `ADDR_W`, 11, memory address width
- `DATA_W`, 8, memory data width

- `vga_clk  in  1  sole clock; all logic on posedge`
- `reset  in  1  asynchronous, active-high`
- `vid_req  in  1  video read request this cycle (chroni text_rom_read slot)`
- `vid_addr  in  ADDR_W  video read address, valid with vid_req`
- `vid_data  out  DATA_W  combinational pass-through of mem_rdata`
- `vid_valid  out  1  vid_data holds the result of the vid_req issued 2 cycles earlier`
- `cpu_req  in  1  CPU request, held high until cpu_ack`
- `cpu_we  in  1  1 = write, 0 = read; valid with cpu_req`
- `cpu_addr  in  ADDR_W  CPU address`
- `cpu_wdata  in  DATA_W  CPU write data`
- `cpu_ack  out  1  one-cycle completion pulse`
- `cpu_rdata  out  DATA_W  registered read data, valid while cpu_ack=1 and held until the next read`
- `mem_addr  out  ADDR_W  registered RAM address`
- `mem_we  out  1  registered RAM write strobe`
- `mem_wdata  out  DATA_W  registered RAM write data`
- `mem_rdata  in  DATA_W  RAM read data; valid one cycle after the mem_addr edge`

## Operation
- **Slot priority.** Evaluated every cycle and registered into `mem_*` at the clock edge.
  - 1: `vid_req`
  - 2: write-buffer drain (`wbuf_valid`)
  - 3: CPU read issue (FSM in IDLE or RD_WAIT, `wbuf_valid=0`)
  - Otherwise idle: `mem_we=0`, `mem_addr` holds its last value.
- **Video path.** On `vid_req`, `mem_addr<=vid_addr` and `mem_we<=0`. A 2-stage shift register tracks the request, and `vid_valid` is stage 2. Video is never stalled or delayed.
- **Write buffer.** Holds one entry: `wbuf_valid`, `wbuf_addr`, `wbuf_data`.
  - Drain: `mem_addr<=wbuf_addr`, `mem_wdata<=wbuf_data`, `mem_we<=1` for exactly one cycle; `wbuf_valid<=0`.
- **CPU FSM states:** IDLE, RD_WAIT, RD_P1, RD_P2, ACK.
  - IDLE, `cpu_req & cpu_we`:
    - `wbuf_valid=0`: capture addr/data, `wbuf_valid<=1`, go to ACK.
    - `wbuf_valid=1`: stay in IDLE.
  - IDLE, `cpu_req & !cpu_we`:
    - slot free (`!vid_req & !wbuf_valid`): `mem_addr<=cpu_addr`, go to RD_P1.
    - slot not free: go to RD_WAIT.
  - RD_WAIT: issue when the slot is free, then go to RD_P1. Because a pending write always drains before the read issues, ordering is in order and read-after-write returns the new data.
  - RD_P1 → RD_P2.
  - RD_P2: `cpu_rdata<=mem_rdata`, go to ACK.
  - ACK: `cpu_ack=1` for one cycle, go to IDLE.
- **Handshake.** The requester drops `cpu_req` at the edge where it sees `cpu_ack`. `cpu_req` high in the cycle after ACK is a new request. `cpu_addr`, `cpu_we` and `cpu_wdata` are sampled only in IDLE or RD_WAIT.
- **Reset (asynchronous).**
  - Outputs: `mem_addr=0`, `mem_we=0`, `mem_wdata=0`, `cpu_ack=0`, `cpu_rdata=0`, `vid_valid=0`.
  - Internal: `wbuf_valid=0`, FSM to IDLE, video pipeline cleared.
  - A read or buffered write in flight at reset is dropped and never acked.

## Timing
- **Video.** `vid_req` in cycle N → RAM address in N+1 → `vid_valid=1` and `vid_data` valid in N+2. Back-to-back `vid_req` gives full throughput.
- **CPU write.** Request sampled in N with an empty buffer → `cpu_ack` in N+1. The RAM write happens in the first cycle ≥ N+1 with `vid_req=0`.
- **CPU read, minimum case.** Slot free in N → `cpu_ack` and `cpu_rdata` valid in N+3.
- **CPU read, with stall.** The read is delayed by one cycle per `vid_req` cycle plus one cycle for a pending drain.
- **Simultaneous events.**
  - `vid_req` and a pending drain in the same cycle: drain is deferred.
  - Write request while a drain happens in the same cycle: the write is captured on the next cycle (it sees `wbuf_valid=0` then).
- **Starvation.** None by design. Chroni leaves ≥12 free slots per 16-cycle fetch group; the CPU waits unboundedly only if `vid_req` is held high continuously.

## Test plan
- **Video latency.** `vid_req=1`, `vid_addr=0x400` for 1 cycle, RAM[0x400]=0x41 → `mem_addr=0x400` in N+1; `vid_valid=1`, `vid_data=0x41` in N+2 only.
- **Write then read.** CPU write 0x123←0x5A, then read 0x123, no video → ack 1 cycle after the write request; `mem_we` pulse with addr 0x123 / data 0x5A; read ack 3 cycles after issue with `cpu_rdata=0x5A`.
- **Write-buffer stall.** Write to 0x010, then an immediate write to 0x011 while `vid_req` is held high for 5 cycles → second ack withheld until after the first drain; both RAM writes occur after `vid_req` falls, in order.
- **Read blocked by video.** `vid_req` high for 8 cycles, CPU read 0x7FF (=0xC3) issued in cycle 0 → zero CPU `mem_addr` use during the burst; `cpu_ack` with 0xC3 3 cycles after `vid_req` drops; `vid_valid` pattern unaffected.
- **Reset mid-read.** Assert `reset` in RD_P1 → all outputs 0 immediately; no `cpu_ack`; after release, a new read 0x000 completes normally.
- **Saturation.** `vid_req` pattern 1010 (repeating) with a CPU read/write stream → every video result arrives exactly 2 cycles later; `mem_we` never coincides with a video slot.
